// File: rtl/shadow_dump_collector.sv
// Shadow dump collector: runs one capture/dump session across CHAINS serial chains,
// packs each chain's bits LSB-first into words and queues them in an output FIFO.
module shadow_dump_collector #(
  parameter int CHAINS     = 1,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        capture_en,
  output logic [CHAINS-1:0]           dump_en,
  input  logic [CHAINS-1:0]           chains_in,
  input  logic [CHAINS-1:0]           chains_in_vld,
  input  logic [CHAINS-1:0]           chains_in_done,
  output logic [WORD_WIDTH-1:0]       word_data,
  output logic [$clog2(CHAINS):0]     word_chain,
  output logic [$clog2(WORD_WIDTH):0] word_bits,
  output logic                        word_last,
  output logic                        word_vld,
  input  logic                        word_rdy,
  output logic                        busy,
  output logic                        session_done
);

  localparam int CW = $clog2(CHAINS) + 1;
  localparam int BW = $clog2(WORD_WIDTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DUMP    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic                  session_done_r;
  logic [WORD_WIDTH-1:0] shift_r     [CHAINS];
  logic [BW-1:0]         cnt_r       [CHAINS];
  logic [WORD_WIDTH-1:0] hold_data_r [CHAINS];
  logic [BW-1:0]         hold_bits_r [CHAINS];
  logic [CHAINS-1:0]     done_seen_r, final_gen_r, hold_vld_r, hold_last_r;
  logic [CHAINS-1:0]     accept_s;
  logic [CW-1:0]         rr_r, sel_s;
  logic                  sel_found_s, push_s, pop_s;
  logic [WORD_WIDTH-1:0] push_data_s;
  logic [BW-1:0]         push_bits_s;
  logic                  push_last_s;
  logic [WORD_WIDTH-1:0] fifo_data_r  [FIFO_DEPTH];
  logic [CW-1:0]         fifo_chain_r [FIFO_DEPTH];
  logic [BW-1:0]         fifo_bits_r  [FIFO_DEPTH];
  logic                  fifo_last_r  [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [AW:0]           fifo_cnt_r;
  logic                  fifo_full_s, fifo_empty_s;

  assign fifo_full_s  = (fifo_cnt_r == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty_s = (fifo_cnt_r == '0);
  assign pop_s        = word_rdy & ~fifo_empty_s;
  assign push_s       = sel_found_s & (~fifo_full_s | pop_s);
  assign accept_s     = chains_in_vld & dump_en;

  assign word_data    = fifo_data_r[rd_ptr_r];
  assign word_chain   = fifo_chain_r[rd_ptr_r];
  assign word_bits    = fifo_bits_r[rd_ptr_r];
  assign word_last    = fifo_last_r[rd_ptr_r];
  assign word_vld     = ~fifo_empty_s;
  assign session_done = session_done_r;

  // State register and the completion pulse raised on the DRAIN to IDLE edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      session_done_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      session_done_r <= (state_r == ST_DRAIN) && fifo_empty_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    state_next_s = start ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: state_next_s = ST_DUMP;
      ST_DUMP:    state_next_s = (&done_seen_r && &final_gen_r && ~|hold_vld_r) ? ST_DRAIN : ST_DUMP;
      ST_DRAIN:   state_next_s = fifo_empty_s ? ST_IDLE : ST_DRAIN;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Session control outputs; a chain is throttled while its packer is full.
  always_comb begin
    capture_en = (state_r == ST_CAPTURE);
    busy       = (state_r != ST_IDLE);
    dump_en    = '0;
    for (int c = 0; c < CHAINS; c++) begin
      dump_en[c] = (state_r == ST_DUMP) && !done_seen_r[c] && (cnt_r[c] < BW'(WORD_WIDTH));
    end
  end

  // Round-robin pick of the next non-empty hold register, searching from rr_r.
  always_comb begin
    int   idx_v;
    logic hit_v;
    idx_v       = 0;
    hit_v       = 1'b0;
    sel_s       = rr_r;
    sel_found_s = 1'b0;
    push_data_s = '0;
    push_bits_s = '0;
    push_last_s = 1'b0;
    for (int k = 0; k < CHAINS; k++) begin
      idx_v       = (int'(rr_r) + k) % CHAINS;
      hit_v       = hold_vld_r[idx_v] & ~sel_found_s;
      sel_s       = hit_v ? CW'(idx_v) : sel_s;
      sel_found_s = sel_found_s | hit_v;
    end
    for (int c = 0; c < CHAINS; c++) begin
      push_data_s = (sel_s == CW'(c)) ? hold_data_r[c] : push_data_s;
      push_bits_s = (sel_s == CW'(c)) ? hold_bits_r[c] : push_bits_s;
      push_last_s = (sel_s == CW'(c)) ? hold_last_r[c] : push_last_s;
    end
  end

  // Per-chain packers, done tracking and hold registers; CAPTURE starts a clean session.
  always_ff @(posedge clk) begin
    if (!rst || (state_r == ST_CAPTURE)) begin
      done_seen_r <= '0;
      final_gen_r <= '0;
      hold_vld_r  <= '0;
      hold_last_r <= '0;
      for (int c = 0; c < CHAINS; c++) begin
        shift_r[c]     <= '0;
        cnt_r[c]       <= '0;
        hold_data_r[c] <= '0;
        hold_bits_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHAINS; c++) begin
        if (push_s && (sel_s == CW'(c))) begin
          hold_vld_r[c] <= 1'b0;
        end
        if (state_r == ST_DUMP) begin
          if (chains_in_done[c]) begin
            done_seen_r[c] <= 1'b1;
          end
          // A full packer always drains before the final (possibly empty) word.
          if (accept_s[c]) begin
            shift_r[c] <= shift_r[c] | (WORD_WIDTH'(chains_in[c]) << cnt_r[c]);
            cnt_r[c]   <= cnt_r[c] + BW'(1'b1);
          end else if (!hold_vld_r[c] && (cnt_r[c] == BW'(WORD_WIDTH))) begin
            hold_data_r[c] <= shift_r[c];
            hold_bits_r[c] <= cnt_r[c];
            hold_last_r[c] <= 1'b0;
            hold_vld_r[c]  <= 1'b1;
            shift_r[c]     <= '0;
            cnt_r[c]       <= '0;
          end else if (!hold_vld_r[c] && done_seen_r[c] && !final_gen_r[c]) begin
            hold_data_r[c] <= shift_r[c];
            hold_bits_r[c] <= cnt_r[c];
            hold_last_r[c] <= 1'b1;
            hold_vld_r[c]  <= 1'b1;
            final_gen_r[c] <= 1'b1;
            shift_r[c]     <= '0;
            cnt_r[c]       <= '0;
          end
        end
      end
    end
  end

  // Output FIFO and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      rr_r       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i]  <= '0;
        fifo_chain_r[i] <= '0;
        fifo_bits_r[i]  <= '0;
        fifo_last_r[i]  <= 1'b0;
      end
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r]  <= push_data_s;
        fifo_chain_r[wr_ptr_r] <= sel_s;
        fifo_bits_r[wr_ptr_r]  <= push_bits_s;
        fifo_last_r[wr_ptr_r]  <= push_last_s;
        wr_ptr_r               <= wr_ptr_r + AW'(1'b1);
        rr_r                   <= (sel_s == CW'(CHAINS - 1)) ? '0 : sel_s + CW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      if (push_s && !pop_s) begin
        fifo_cnt_r <= fifo_cnt_r + (AW+1)'(1'b1);
      end else if (!push_s && pop_s) begin
        fifo_cnt_r <= fifo_cnt_r - (AW+1)'(1'b1);
      end else begin
        fifo_cnt_r <= fifo_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_shadow_dump_collector.sv
// Bench for shadow_dump_collector: chain sources driven from bit vectors, outputs
// checked against per-chain word lists computed from the packing rules.
module tb_shadow_dump_collector;

  localparam int CH = 2;
  localparam int WW = 8;
  localparam int FD = 4;

  typedef logic [12:0] word_t;  // {data[7:0], bits[3:0], last}

  logic       clk = 1'b0;
  logic       rst, start, capture_en, word_last, word_vld, word_rdy, busy, session_done;
  logic [1:0] dump_en, chains_in, chains_in_vld, chains_in_done, word_chain;
  logic [7:0] word_data;
  logic [3:0] word_bits;

  int          checks = 0;
  int          failures = 0;
  word_t       exp0[$];
  word_t       exp1[$];
  int          pop_log[$];
  logic [63:0] sbits[2];
  int          slen[2];
  bit          dwl[2];
  int          sidx[2];
  bit          gate_rand;
  int          rdy_mode;
  int          sd_cnt;
  bit          hold_chk;
  logic [15:0] held;

  always #5 clk = ~clk;

  shadow_dump_collector #(.CHAINS(CH), .WORD_WIDTH(WW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .capture_en(capture_en), .dump_en(dump_en),
    .chains_in(chains_in), .chains_in_vld(chains_in_vld), .chains_in_done(chains_in_done),
    .word_data(word_data), .word_chain(word_chain), .word_bits(word_bits),
    .word_last(word_last), .word_vld(word_vld), .word_rdy(word_rdy),
    .busy(busy), .session_done(session_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full bytes with last=0, then the remainder (possibly zero bits) with last=1.
  task automatic build_exp(input int c);
    int          full, rem;
    logic [63:0] mask;
    word_t       w;
    full = slen[c] / 8;
    rem  = slen[c] % 8;
    mask = (64'd1 << rem) - 64'd1;
    for (int k = 0; k < full; k++) begin
      w = {8'(sbits[c] >> (8 * k)), 4'd8, 1'b0};
      if (c == 0) exp0.push_back(w); else exp1.push_back(w);
    end
    w = {8'((sbits[c] >> (8 * full)) & mask), 4'(rem), 1'b1};
    if (c == 0) exp0.push_back(w); else exp1.push_back(w);
  endtask

  task automatic pop_check();
    word_t obs;
    obs = {word_data, word_bits, word_last};
    pop_log.push_back(int'(word_chain));
    check("word_chain_range", 32'(word_chain < 2'd2), 32'd1);
    if (word_chain == 2'd0) begin
      check("c0_word_expected", 32'(exp0.size() > 0), 32'd1);
      if (exp0.size() > 0) check("c0_word", 32'(obs), 32'(exp0.pop_front()));
    end else if (word_chain == 2'd1) begin
      check("c1_word_expected", 32'(exp1.size() > 0), 32'd1);
      if (exp1.size() > 0) check("c1_word", 32'(obs), 32'(exp1.pop_front()));
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic tick();
    logic [1:0] acc;
    bit         g;
    if (hold_chk) check("hold_stable", 32'({word_vld, word_chain, word_data, word_bits, word_last}), 32'(held));
    case (rdy_mode)
      0:       word_rdy = 1'b1;
      1:       word_rdy = ($urandom_range(0, 2) != 0);
      default: word_rdy = 1'b0;
    endcase
    hold_chk = word_vld && !word_rdy;
    held     = {word_vld, word_chain, word_data, word_bits, word_last};
    if (word_vld && word_rdy) pop_check();
    if (session_done) sd_cnt++;
    start = busy && ($urandom_range(0, 7) == 0);
    for (int c = 0; c < 2; c++) begin
      g = gate_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sidx[c] < slen[c]) begin
        chains_in_vld[c] = g;
        chains_in[c]     = sbits[c][sidx[c]];
      end else begin
        chains_in_vld[c] = 1'b0;
        chains_in[c]     = 1'($urandom);
      end
      chains_in_done[c] = (sidx[c] == slen[c]) ||
                          (dwl[c] && (sidx[c] == slen[c] - 1) && chains_in_vld[c] && dump_en[c]);
      acc[c] = chains_in_vld[c] & dump_en[c];
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) sidx[c] += int'(acc[c]);
    @(negedge clk);
  endtask

  task automatic start_session(input logic [63:0] b0, input int l0, input bit d0,
                               input logic [63:0] b1, input int l1, input bit d1);
    sbits[0] = b0; slen[0] = l0; dwl[0] = d0; sidx[0] = 0;
    sbits[1] = b1; slen[1] = l1; dwl[1] = d1; sidx[1] = 0;
    exp0.delete(); exp1.delete(); pop_log.delete();
    build_exp(0); build_exp(1);
    sd_cnt = 0;
    chains_in_vld = 2'b00; chains_in_done = 2'b00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("capture_en", 32'(capture_en), 32'd1);
    check("busy_capture", 32'(busy), 32'd1);
    check("dump_en_capture", 32'(dump_en), 32'd0);
  endtask

  task automatic finish_session(input string tag);
    int n;
    n = 0;
    while (sd_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(sd_cnt), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_vld_idle"}, 32'(word_vld), 32'd0);
    repeat (3) tick();
    check({tag, "_done_once"}, 32'(sd_cnt), 32'd1);
    check({tag, "_c0_left"}, 32'(exp0.size()), 32'd0);
    check({tag, "_c1_left"}, 32'(exp1.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; word_rdy = 1'b0;
    chains_in = 2'b00; chains_in_vld = 2'b00; chains_in_done = 2'b00;
    gate_rand = 1'b0; rdy_mode = 0; hold_chk = 1'b0; sd_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_capture_en", 32'(capture_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dump_en", 32'(dump_en), 32'd0);
    check("rst_word_vld", 32'(word_vld), 32'd0);
    check("rst_session_done", 32'(session_done), 32'd0);
    check("rst_word_fields", 32'({word_data, word_bits, word_chain, word_last}), 32'd0);

    // Start in the reset-release cycle: 20 bits on chain 0, empty chain 1.
    rst = 1'b1;
    start_session(64'h0F3C5A, 20, 1'b0, 64'h0, 0, 1'b0);
    finish_session("basic");

    // Exactly 16 bits with done on the final bit, random stalls both sides.
    gate_rand = 1'b1; rdy_mode = 1;
    start_session({$urandom, $urandom}, 16, 1'b1, {$urandom, $urandom}, 16, 1'b1);
    finish_session("exact16");

    // One-cycle reset after five bits of DUMP.
    gate_rand = 1'b0;
    start_session({$urandom, $urandom}, 30, 1'b0, {$urandom, $urandom}, 30, 1'b0);
    n = 0;
    while (sidx[0] < 5 && n < 50) begin
      tick();
      n++;
    end
    check("five_bits", 32'(sidx[0]), 32'd5);
    rst = 1'b0; start = 1'b0; chains_in_vld = 2'b00; chains_in_done = 2'b00; hold_chk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dump_en", 32'(dump_en), 32'd0);
    check("midrst_word_vld", 32'(word_vld), 32'd0);
    check("midrst_capture_en", 32'(capture_en), 32'd0);
    check("midrst_word_fields", 32'({word_data, word_bits, word_chain, word_last}), 32'd0);

    // Back-pressure until everything is full: each chain can hold 2 FIFO words,
    // one hold word and one full packer, i.e. 32 bits, before being throttled.
    rdy_mode = 2;
    start_session({$urandom, $urandom}, 40, 1'b0, {$urandom, $urandom}, 40, 1'b0);
    repeat (60) tick();
    check("stall_dump_en", 32'(dump_en), 32'd0);
    check("stall_c0_bits", 32'(sidx[0]), 32'd32);
    check("stall_c1_bits", 32'(sidx[1]), 32'd32);
    rdy_mode = 0;
    finish_session("stall");
    check("alt_count", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("alt_chain", 32'(pop_log[k]), 32'(k % 2));
    end

    // Randomized sessions.
    gate_rand = 1'b1; rdy_mode = 1;
    for (int s = 0; s < 6; s++) begin
      start_session({$urandom, $urandom}, $urandom_range(0, 60), 1'($urandom),
                    {$urandom, $urandom}, $urandom_range(0, 60), 1'($urandom));
      finish_session("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
